ring_monitor: RTL and testbench
===============================

Name: ring_monitor

Overview:
Receive-side companion to the one-hot ring counter. Samples an N-bit one-hot ring code every enabled clock and decodes it to a binary phase index. Checks that the code advances by exactly one position per enabled cycle, acquires lock after a run of good steps, and counts completed revolutions. Latches a fault with a cause code on any violation while locked. Sits beside any ring-counter sequencer as its decoder and health checker.

Parameters:
N, 3, ring width in bits; must be >= 2
IW, $clog2(N), width of the decoded index
LOCK_CNT, 2, consecutive correct advances required to enter LOCKED; must be >= 1
REV_W, 8, width of the revolution counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  sample enable; when 0, all state is frozen
clr  input  1  synchronous fault clear; not gated by en
ring_in  input  N  ring code; bit i set means phase i
idx  output  IW  decoded phase of the last legal sample
idx_valid  output  1  last enabled sample was legal one-hot
locked  output  1  state is LOCKED
fault  output  1  state is FAULT (sticky)
err_code  output  2  00 none, 01 not one-hot, 10 wrong step
rev_count  output  REV_W  revolutions completed while LOCKED

Behaviour:
- rst low, asynchronously: state=SEARCH, idx=0, idx_valid=0, good_cnt=0, locked=0, fault=0, err_code=00, rev_count=0. Applies immediately, including mid-operation.
- All outputs are registered. Latency is 1 cycle from ring_in to idx/idx_valid/locked/fault.
- Decode is combinational on ring_in:
  - legal = exactly one bit set; d_idx = position of that bit.
  - step_ok = legal & idx_valid & (d_idx == (idx+1) mod N).
  - Wrap is N-1 -> 0.
- Enabled edge (en=1, clr=0):
  - Legal sample: idx<=d_idx, idx_valid<=1.
  - Illegal sample: idx holds, idx_valid<=0.
- en=0 and clr=0: nothing changes, including good_cnt. A stalled ring is not checked.
- clr=1 has priority over en and over all state transitions: state<=SEARCH, fault<=0, err_code<=00, good_cnt<=0, idx_valid<=0. idx and rev_count hold.
- SEARCH:
  - On step_ok, good_cnt++. When the increment reaches LOCK_CNT, go to LOCKED on the same edge and set good_cnt<=0.
  - Legal but not step_ok, or illegal: good_cnt<=0.
  - No faults are raised in SEARCH.
- LOCKED:
  - On step_ok, stay. If d_idx==0 (wrap from N-1), rev_count++ modulo 2^REV_W.
  - Illegal sample: go to FAULT, err_code<=01.
  - Legal but not step_ok (hold, skip, or backward): go to FAULT, err_code<=10.
- FAULT:
  - Sticky until clr. rev_count frozen; err_code holds its first cause.
  - idx/idx_valid keep tracking enabled samples.
- locked = (state==LOCKED); fault = (state==FAULT). Encoding: SEARCH=00, LOCKED=01, FAULT=10. Code 11 is unreachable and recovers to SEARCH.
- rst low overrides clr and en.

Test Plan:
- Reset: drive 010 and run locked; assert rst low between edges -> all outputs 0 immediately, without waiting for a clock. Release and feed 001 -> idx=0, idx_valid=1, locked=0.
- Lock acquisition (N=3, LOCK_CNT=2): en=1, feed 001,010,100 on three edges.
  - After edge 1: idx=0.
  - After edge 2: idx=1.
  - After edge 3: idx=2, locked=1.
  - Then 001 -> idx=0, rev_count=1.
- Revolution wrap (REV_W=8): stay locked for 256 full revolutions -> rev_count returns to 0, locked=1, fault=0.
- Illegal code: while locked at idx=1, feed 011 -> fault=1, err_code=01, locked=0, idx_valid=0, idx=1, rev_count unchanged. Pulse clr -> fault=0, err_code=00, state SEARCH.
- Wrong step: locked at idx=1, feed 010 -> fault=1, err_code=10. Separately, from idx=1 feed 001 (backward) -> err_code=10.
- Enable/clear interaction:
  - Locked at idx=2, drop en for 5 cycles while driving 000 -> no change.
  - Raise en with 001 -> rev_count++.
  - In FAULT, assert clr with en=0 -> clear still occurs.
  - clr together with a violating sample -> SEARCH, fault=0.

Source files
------------

// File: rtl/ring_monitor.sv
// Decodes a one-hot ring code to a phase index, tracks lock, counts revolutions, latches faults.
// Latency: 1 cycle from ring_in to every output (all outputs come from registered state).
// Backpressure: none; en=0 freezes all state, clr clears the fault regardless of en.
module ring_monitor #(
    parameter int N        = 3,
    parameter int IW       = $clog2(N),
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     ring_in,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       err_code,
    output logic [REV_W-1:0] rev_count
);

    localparam logic [1:0] S_SEARCH = 2'b00;
    localparam logic [1:0] S_LOCKED = 2'b01;
    localparam logic [1:0] S_FAULT  = 2'b10;

    localparam logic [1:0] E_NONE   = 2'b00;
    localparam logic [1:0] E_ONEHOT = 2'b01;
    localparam logic [1:0] E_STEP   = 2'b10;

    // Counter only ever holds 0..LOCK_CNT-1; the increment may reach LOCK_CNT.
    localparam int CW = $clog2(LOCK_CNT + 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_idx_valid;
    logic [CW-1:0]    r_good_cnt;
    logic [1:0]       r_err_code;
    logic [REV_W-1:0] r_rev_count;

    logic             w_legal;
    logic [IW-1:0]    w_d_idx;
    logic [IW-1:0]    w_idx_next;
    logic             w_step_ok;
    logic [CW-1:0]    w_good_inc;

    // Decode the incoming code and judge whether it is exactly one step ahead of the last sample.
    always_comb begin
        w_d_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_in[i]) begin
                w_d_idx = IW'(i);
            end
        end
        w_legal    = $onehot(ring_in);
        w_idx_next = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
        w_step_ok  = w_legal & r_idx_valid & (w_d_idx == w_idx_next);
        w_good_inc = r_good_cnt + CW'(1);
    end

    // Phase tracking, lock state machine, fault capture and revolution counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_SEARCH;
            r_idx       <= '0;
            r_idx_valid <= 1'b0;
            r_good_cnt  <= '0;
            r_err_code  <= E_NONE;
            r_rev_count <= '0;
        end else if (clr) begin
            // idx and rev_count deliberately survive a clear.
            r_state     <= S_SEARCH;
            r_idx_valid <= 1'b0;
            r_good_cnt  <= '0;
            r_err_code  <= E_NONE;
        end else if (en) begin
            // Phase tracking continues in every state, including FAULT.
            if (w_legal) begin
                r_idx       <= w_d_idx;
                r_idx_valid <= 1'b1;
            end else begin
                r_idx_valid <= 1'b0;
            end

            case (r_state)
                S_SEARCH: begin
                    if (w_step_ok) begin
                        if (w_good_inc == CW'(LOCK_CNT)) begin
                            r_state    <= S_LOCKED;
                            r_good_cnt <= '0;
                        end else begin
                            r_good_cnt <= w_good_inc;
                        end
                    end else begin
                        r_good_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (w_step_ok) begin
                        // A correct step landing on phase 0 can only come from N-1.
                        if (w_d_idx == '0) begin
                            r_rev_count <= r_rev_count + REV_W'(1);
                        end
                    end else if (!w_legal) begin
                        r_state    <= S_FAULT;
                        r_err_code <= E_ONEHOT;
                    end else begin
                        r_state    <= S_FAULT;
                        r_err_code <= E_STEP;
                    end
                end
                S_FAULT: begin
                    // Sticky until clr; first cause is kept.
                end
                default: begin
                    r_state    <= S_SEARCH;
                    r_good_cnt <= '0;
                    r_err_code <= E_NONE;
                end
            endcase
        end
    end

    assign idx       = r_idx;
    assign idx_valid = r_idx_valid;
    assign locked    = (r_state == S_LOCKED);
    assign fault     = (r_state == S_FAULT);
    assign err_code  = r_err_code;
    assign rev_count = r_rev_count;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; the bench drives en/clr directly.
module tb_ring_monitor;

    localparam int N        = 3;
    localparam int IW       = $clog2(N);
    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             clr;
    logic [N-1:0]     ring_in;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             locked;
    logic             fault;
    logic [1:0]       err_code;
    logic [REV_W-1:0] rev_count;

    ring_monitor #(
        .N(N), .IW(IW), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ring_in(ring_in),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .fault(fault),
        .err_code(err_code), .rev_count(rev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 = searching, 1 = locked, 2 = faulted.
    int m_mode;
    int m_idx;
    int m_valid;
    int m_good;
    int m_err;
    int m_rev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_valid = 0; m_good = 0; m_err = 0; m_rev = 0;
    endtask

    // One clock edge of the behaviour, phrased as rules on phase positions.
    task automatic model_edge(input logic e, input logic c, input logic [N-1:0] r);
        int  ones;
        int  pos;
        bit  legal;
        bit  advance;
        ones = 0;
        pos  = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                ones++;
                pos = i;
            end
        end
        legal = (ones == 1);
        if (c) begin
            m_mode = 0; m_good = 0; m_valid = 0; m_err = 0;
        end else if (e) begin
            advance = legal && (m_valid == 1) && (pos == (m_idx + 1) % N);
            if (m_mode == 0) begin
                if (advance) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_mode = 1;
                        m_good = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else if (m_mode == 1) begin
                if (advance) begin
                    if (pos == 0) m_rev = (m_rev + 1) % (1 << REV_W);
                end else begin
                    m_mode = 2;
                    m_err  = legal ? 2 : 1;
                end
            end
            if (legal) begin
                m_idx   = pos;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".idx"},       32'(idx),       32'(m_idx));
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(m_valid));
        chk({tag, ".locked"},    32'(locked),    32'(m_mode == 1));
        chk({tag, ".fault"},     32'(fault),     32'(m_mode == 2));
        chk({tag, ".err_code"},  32'(err_code),  32'(m_err));
        chk({tag, ".rev_count"}, 32'(rev_count), 32'(m_rev));
    endtask

    // Called just after an edge: present inputs, take one edge, update the model, compare.
    task automatic step(input string tag, input logic e, input logic c, input logic [N-1:0] r);
        en = e; clr = c; ring_in = r;
        @(posedge clk);
        model_edge(e, c, r);
        #1;
        check_all(tag);
    endtask

    function automatic logic [N-1:0] code_of(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // From any state: clear, then walk 0,1,2 (lock), 0 (revolution), 1.
    task automatic relock_to_1(input string tag);
        step({tag, ".clr"}, 1'b1, 1'b1, 3'b000);
        for (int k = 0; k < 5; k++) step(tag, 1'b1, 1'b0, code_of(k % N));
        chk({tag, ".locked_at1"}, 32'(locked), 32'd1);
        chk({tag, ".idx1"},       32'(idx),    32'd1);
    endtask

    initial begin
        int r;
        int rev_snap;
        logic [N-1:0] v;
        logic e;
        logic c;

        rst = 1'b0; en = 1'b0; clr = 1'b0; ring_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_state");
        rst = 1'b1;

        // Lock, then assert reset between edges and verify outputs drop without a clock.
        for (int k = 0; k < 4; k++) step("prelock", 1'b1, 1'b0, code_of(k % N));
        step("run010", 1'b1, 1'b0, 3'b010);
        chk("prelock.locked", 32'(locked), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("post_reset", 1'b1, 1'b0, 3'b001);
        chk("post_reset.idx",    32'(idx),       32'd0);
        chk("post_reset.valid",  32'(idx_valid), 32'd1);
        chk("post_reset.locked", 32'(locked),    32'd0);

        // Lock acquisition from a fresh search.
        step("lk.clr", 1'b1, 1'b1, 3'b000);
        step("lk.e1", 1'b1, 1'b0, 3'b001);
        chk("lk.e1.idx", 32'(idx), 32'd0);
        step("lk.e2", 1'b1, 1'b0, 3'b010);
        chk("lk.e2.idx", 32'(idx), 32'd1);
        step("lk.e3", 1'b1, 1'b0, 3'b100);
        chk("lk.e3.idx",    32'(idx),    32'd2);
        chk("lk.e3.locked", 32'(locked), 32'd1);
        step("lk.wrap", 1'b1, 1'b0, 3'b001);
        chk("lk.wrap.rev", 32'(rev_count), 32'd1 + 32'(rev_snap * 0));

        // 255 more revolutions bring the 8-bit counter from 1 back to 0.
        for (int k = 0; k < 255 * N; k++) step("revs", 1'b1, 1'b0, code_of((k + 1) % N));
        chk("revs.rev",    32'(rev_count), 32'd0);
        chk("revs.locked", 32'(locked),    32'd1);
        chk("revs.fault",  32'(fault),     32'd0);

        // Illegal code while locked at phase 1.
        step("ill.to1", 1'b1, 1'b0, 3'b010);
        step("ill", 1'b1, 1'b0, 3'b011);
        chk("ill.fault", 32'(fault),     32'd1);
        chk("ill.err",   32'(err_code),  32'd1);
        chk("ill.valid", 32'(idx_valid), 32'd0);
        chk("ill.idx",   32'(idx),       32'd1);
        chk("ill.rev",   32'(rev_count), 32'd0);
        step("ill.clr", 1'b1, 1'b1, 3'b011);
        chk("ill.clr.fault", 32'(fault),    32'd0);
        chk("ill.clr.err",   32'(err_code), 32'd0);

        // Wrong step: hold at phase 1, then backward to 0.
        relock_to_1("hold");
        step("hold.bad", 1'b1, 1'b0, 3'b010);
        chk("hold.err", 32'(err_code), 32'd2);
        relock_to_1("back");
        step("back.bad", 1'b1, 1'b0, 3'b001);
        chk("back.err", 32'(err_code), 32'd2);
        step("back.sticky", 1'b1, 1'b0, 3'b110);
        chk("back.sticky.err", 32'(err_code), 32'd2);

        // Enable and clear interaction.
        relock_to_1("en");
        step("en.to2", 1'b1, 1'b0, 3'b100);
        rev_snap = m_rev;
        for (int k = 0; k < 5; k++) step("en.stall", 1'b0, 1'b0, 3'b000);
        chk("en.stall.locked", 32'(locked), 32'd1);
        chk("en.stall.idx",    32'(idx),    32'd2);
        step("en.resume", 1'b1, 1'b0, 3'b001);
        chk("en.resume.rev", 32'(rev_count), 32'((rev_snap + 1) % 256));
        step("en.hold", 1'b1, 1'b0, 3'b001);
        chk("en.hold.fault", 32'(fault), 32'd1);
        step("en.clr_noen", 1'b0, 1'b1, 3'b000);
        chk("en.clr_noen.fault", 32'(fault), 32'd0);
        relock_to_1("clrviol");
        step("clrviol", 1'b1, 1'b1, 3'b111);
        chk("clrviol.fault",  32'(fault),  32'd0);
        chk("clrviol.locked", 32'(locked), 32'd0);

        // Randomized traffic: mostly correct advances with injected errors, stalls and clears.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      v = code_of(m_valid == 1 ? (m_idx + 1) % N : int'($urandom_range(0, N - 1)));
            else if (r < 90) v = N'($urandom_range(0, (1 << N) - 1));
            else             v = code_of(int'($urandom_range(0, N - 1)));
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 39) == 0);
            step("rand", e, c, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
